fcp_rx_ctrl: RTL and testbench

Single-wire FCP receive controller, the receiving end of the link driven by the FCP transmit controller. It synchronises the line, detects the master ping, recovers the quarter-UI sync pattern, samples 8 data bits plus parity per byte, and detects the frame-ending ping. Decoded bytes stream out to the upper protocol layer, which performs CRC checking.

---
 rtl/fcp_rx_ctrl_if.sv | 24 ++
 rtl/fcp_rx_ctrl.sv | 140 ++++++++++++++
 tb/tb_fcp_rx_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fcp_rx_ctrl_if.sv
// Line and decoded-byte signals of the FCP receive controller.
// The slave side is the receiver; the master side drives the line and consumes the byte stream.
interface fcp_rx_ctrl_if;
  logic       rx_en;
  logic       data_in;
  logic [7:0] rx_byte;
  logic       rx_byte_vld;
  logic       rx_par_err;
  logic       rx_ping;
  logic       rx_done;
  logic [1:0] rx_byte_cnt;
  logic       rx_busy;

  // rx_byte_vld is a one-cycle strobe with no back-pressure; rx_byte/rx_par_err stay stable until the next strobe.
  modport slave (
    input  rx_en, data_in,
    output rx_byte, rx_byte_vld, rx_par_err, rx_ping, rx_done, rx_byte_cnt, rx_busy
  );

  modport master (
    output rx_en, data_in,
    input  rx_byte, rx_byte_vld, rx_par_err, rx_ping, rx_done, rx_byte_cnt, rx_busy
  );
endinterface

// File: rtl/fcp_rx_ctrl.sv
// Single-wire FCP receiver: ping detection, sync recovery, mid-bit sampling of 8 data bits plus
// odd parity, and end-of-frame detection. The FSM state is exported on o_dbg_state.
module fcp_rx_ctrl #(
  parameter int UI_CYCLE    = 20,
  parameter int PING_MIN_UI = 12
) (
  input  logic              clk,
  input  logic              rst,
  fcp_rx_ctrl_if.slave      bus,
  output logic [2:0]        o_dbg_state
);

  localparam logic [15:0] PING_TH_W = 16'(PING_MIN_UI * UI_CYCLE);
  localparam logic [15:0] HALF_W    = 16'(UI_CYCLE / 2);
  localparam logic [15:0] UI_W      = 16'(UI_CYCLE);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PING = 3'd1,
    S_SYNC = 3'd2,
    S_DATA = 3'd3,
    S_HOLD = 3'd4,
    S_TAIL = 3'd5
  } state_t;

  state_t      r_state;
  logic        r_ff1, r_ff2, r_ff3;
  logic [15:0] r_run_cnt;
  logic [15:0] r_smp_cnt;
  logic [8:0]  r_shift;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_byte;
  logic        r_vld, r_par_err, r_ping, r_done;
  logic [1:0]  r_byte_cnt;

  logic w_edge, w_rise, w_fall, w_run_sat, w_timing, w_smp_hit, w_end;

  assign w_edge    = r_ff2 ^ r_ff3;
  assign w_rise    = w_edge & r_ff2;
  assign w_fall    = w_edge & ~r_ff2;
  assign w_run_sat = &r_run_cnt;
  assign w_timing  = (r_state == S_SYNC) || (r_state == S_DATA);
  // The sample fires as the timer steps to zero, so samples land HALF, HALF+UI, ... after an edge.
  assign w_smp_hit = w_timing && !w_edge && (r_smp_cnt == 16'd1);
  // Frame end is flagged in the cycle run_cnt becomes PING_TH; an edge in that cycle takes priority.
  assign w_end     = ((r_state == S_SYNC) || (r_state == S_DATA) || (r_state == S_HOLD)) &&
                     !w_edge && (r_run_cnt == PING_TH_W - 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ff1      <= 1'b0;
      r_ff2      <= 1'b0;
      r_ff3      <= 1'b0;
      r_run_cnt  <= '0;
      r_smp_cnt  <= HALF_W;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_state    <= S_IDLE;
      r_byte     <= '0;
      r_vld      <= 1'b0;
      r_par_err  <= 1'b0;
      r_ping     <= 1'b0;
      r_done     <= 1'b0;
      r_byte_cnt <= '0;
    end else begin
      r_ff1  <= bus.data_in;
      r_ff2  <= r_ff1;
      r_ff3  <= r_ff2;
      r_vld  <= 1'b0;
      r_ping <= 1'b0;
      r_done <= 1'b0;
      if (!bus.rx_en) begin
        r_state   <= S_IDLE;
        r_run_cnt <= '0;
        r_smp_cnt <= HALF_W;
        r_shift   <= '0;
        r_bit_cnt <= '0;
      end else begin
        if (w_edge)          r_run_cnt <= '0;
        else if (!w_run_sat) r_run_cnt <= r_run_cnt + 16'd1;

        if (w_edge)        r_smp_cnt <= HALF_W;
        else if (w_timing) r_smp_cnt <= w_smp_hit ? UI_W : r_smp_cnt - 16'd1;

        case (r_state)
          S_IDLE: if (w_rise) r_state <= S_PING;
          S_PING: begin
            if (w_fall) begin
              if (r_run_cnt >= PING_TH_W) begin
                r_ping     <= 1'b1;
                r_byte_cnt <= '0;
                r_state    <= S_SYNC;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end
          S_SYNC, S_DATA, S_HOLD: begin
            if (w_end) begin
              r_done    <= 1'b1;
              r_shift   <= '0;
              r_bit_cnt <= '0;
              r_state   <= r_ff2 ? S_TAIL : S_IDLE;
            end else if (r_state == S_HOLD) begin
              // The committing edge doubles as the first sync edge of the next byte.
              if (w_edge) begin
                r_byte     <= r_shift[8:1];
                r_par_err  <= ~^r_shift;
                r_vld      <= 1'b1;
                r_byte_cnt <= (r_byte_cnt == 2'd3) ? 2'd3 : r_byte_cnt + 2'd1;
                r_state    <= S_SYNC;
              end
            end else if (w_smp_hit) begin
              r_shift <= {r_shift[7:0], r_ff2};
              if (r_state == S_SYNC) begin
                r_bit_cnt <= 4'd1;
                r_state   <= S_DATA;
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
                if (r_bit_cnt == 4'd8) r_state <= S_HOLD;
              end
            end
          end
          S_TAIL:  if (w_fall) r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.rx_byte     = r_byte;
  assign bus.rx_byte_vld = r_vld;
  assign bus.rx_par_err  = r_par_err;
  assign bus.rx_ping     = r_ping;
  assign bus.rx_done     = r_done;
  assign bus.rx_byte_cnt = r_byte_cnt;
  assign bus.rx_busy     = (r_state != S_IDLE);
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_fcp_rx_ctrl.sv
// Bench for fcp_rx_ctrl: table of whole frames driven through a small line transmitter,
// plus hand sequences for glitch, enable and mid-frame reset.
module tb_fcp_rx_ctrl;
  localparam int Q = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line = 1'b0;
  logic [2:0] dbg_state;
  int cyc = 0;
  int last_chg = 0;

  fcp_rx_ctrl_if bus ();
  assign bus.data_in = line;

  fcp_rx_ctrl #(.UI_CYCLE(20), .PING_MIN_UI(12)) dut (
    .clk(clk), .rst(rst), .bus(bus), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  logic [8:0] exp_q[$];

  int ping_cnt, vld_cnt, done_cnt, dis_pulses;
  int ping_gap, done_gap;
  logic [1:0] done_bytes;
  logic [2:0] done_state;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Monitor / scoreboard on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rx_byte_vld) begin
        vld_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got %0h with nothing expected", bus.rx_byte);
        end else begin
          check("byte_par", {23'd0, bus.rx_par_err, bus.rx_byte}, {23'd0, exp_q.pop_front()});
        end
      end
      if (bus.rx_ping) begin
        ping_cnt++;
        ping_gap = cyc - last_chg;
      end
      if (bus.rx_done) begin
        done_cnt++;
        done_gap   = cyc - last_chg;
        done_bytes = bus.rx_byte_cnt;
        done_state = dbg_state;
      end
      if (!bus.rx_en && (bus.rx_byte_vld || bus.rx_ping || bus.rx_done)) dis_pulses++;
    end
  end

  task automatic clear_counts();
    ping_cnt = 0; vld_cnt = 0; done_cnt = 0; dis_pulses = 0;
    ping_gap = -1; done_gap = -1; done_bytes = 2'd0; done_state = 3'd7;
  endtask

  // ---------------- line transmitter ----------------
  task automatic set_line(input logic v, input int n);
    if (v !== line) last_chg = cyc;
    line = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_ping();
    set_line(1'b1, 320);
    set_line(1'b0, Q);
  endtask

  task automatic sync_to(input logic b7);
    for (int k = 0; k < 3; k++) set_line(~line, Q);
    if (line == b7) set_line(~line, Q);
  endtask

  // The parity bit is stretched by half a nominal UI so a long equal-bit run at the slow
  // end of the UI range still gets its ninth sample before the next sync edge.
  task automatic send_byte(input logic [7:0] d, input logic flip, input int ui);
    logic [8:0] w;
    w = {d, (~^d) ^ flip};
    sync_to(d[7]);
    for (int k = 8; k >= 0; k--) set_line(w[k], (k == 0) ? ui + 10 : ui);
  endtask

  task automatic send_end();
    for (int k = 0; k < 3; k++) set_line(~line, Q);
    if (line) set_line(1'b0, Q);
    set_line(1'b1, 320);
    set_line(1'b0, 40);
  endtask

  // ---------------- frame table ----------------
  typedef struct {
    int          n;
    logic [31:0] d;
    logic [3:0]  flip;
    int          ui;
    logic [31:0] exp_b;
    logic [3:0]  exp_err;
    logic [1:0]  exp_cnt;
    logic        exp_tail;
  } frame_t;

  frame_t tbl[7];

  task automatic run_frame(input frame_t f, input string tag);
    for (int i = 0; i < f.n; i++) exp_q.push_back({f.exp_err[i], f.exp_b[8*i +: 8]});
    clear_counts();
    send_ping();
    for (int i = 0; i < f.n; i++) send_byte(f.d[8*i +: 8], f.flip[i], f.ui);
    if (f.n > 0) send_end();
    else         set_line(1'b0, 300);
    check({tag, "_ping_cnt"},  ping_cnt, 1);
    check({tag, "_vld_cnt"},   vld_cnt, f.n);
    check({tag, "_done_cnt"},  done_cnt, 1);
    check({tag, "_done_gap"},  done_gap, 243);
    check({tag, "_byte_cnt"},  {30'd0, done_bytes}, {30'd0, f.exp_cnt});
    check({tag, "_done_state"}, {29'd0, done_state}, f.exp_tail ? 32'd5 : 32'd0);
    check({tag, "_q_empty"},   exp_q.size(), 0);
    check({tag, "_idle"},      {29'd0, dbg_state}, 0);
    check({tag, "_busy"},      {31'd0, bus.rx_busy}, 0);
    if (f.n == 0) check({tag, "_ping_gap"}, ping_gap, 3);
    if (f.n > 0) begin
      check({tag, "_last_byte"}, {24'd0, bus.rx_byte}, {24'd0, f.exp_b[8*(f.n-1) +: 8]});
      check({tag, "_last_err"},  {31'd0, bus.rx_par_err}, {31'd0, f.exp_err[f.n-1]});
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_byte"},  {24'd0, bus.rx_byte}, 0);
    check({tag, "_vld"},   {31'd0, bus.rx_byte_vld}, 0);
    check({tag, "_err"},   {31'd0, bus.rx_par_err}, 0);
    check({tag, "_ping"},  {31'd0, bus.rx_ping}, 0);
    check({tag, "_done"},  {31'd0, bus.rx_done}, 0);
    check({tag, "_cnt"},   {30'd0, bus.rx_byte_cnt}, 0);
    check({tag, "_busy"},  {31'd0, bus.rx_busy}, 0);
    check({tag, "_state"}, {29'd0, dbg_state}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 32'h0,        4'h0, 20, 32'h0,        4'h0, 2'd0, 1'b0};
    tbl[1] = '{1, 32'h08,       4'h0, 20, 32'h08,       4'h0, 2'd1, 1'b1};
    tbl[2] = '{1, 32'h08,       4'h1, 20, 32'h08,       4'h1, 2'd1, 1'b1};
    tbl[3] = '{3, 32'h00FF3CA5, 4'h0, 18, 32'h00FF3CA5, 4'h0, 2'd3, 1'b1};
    tbl[4] = '{3, 32'h00FF3CA5, 4'h0, 22, 32'h00FF3CA5, 4'h0, 2'd3, 1'b1};
    tbl[5] = '{2, 32'h7E81,     4'h2, 20, 32'h7E81,     4'h2, 2'd2, 1'b1};
    tbl[6] = '{4, 32'h88442211, 4'h0, 20, 32'h88442211, 4'h0, 2'd3, 1'b1};

    // clock/reset
    bus.rx_en = 1'b1;
    clear_counts();
    repeat (3) @(negedge clk);
    check_all_zero("in_reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_all_zero("after_reset");

    for (int i = 0; i < 7; i++) begin
      run_frame(tbl[i], $sformatf("frame%0d", i));
      set_line(1'b0, 20);
    end

    // glitch: 3 UI high in IDLE
    clear_counts();
    set_line(1'b1, 30);
    check("glitch_busy_mid",  {31'd0, bus.rx_busy}, 1);
    check("glitch_state_mid", {29'd0, dbg_state}, 1);
    set_line(1'b1, 30);
    set_line(1'b0, 40);
    check("glitch_no_ping", ping_cnt, 0);
    check("glitch_idle",    {29'd0, dbg_state}, 0);
    check("glitch_busy",    {31'd0, bus.rx_busy}, 0);
    check("cnt_hold",       {30'd0, bus.rx_byte_cnt}, 3);

    // receiver disabled right after the ping
    clear_counts();
    send_ping();
    bus.rx_en = 1'b0;
    send_byte(8'h5A, 1'b0, 20);
    send_end();
    set_line(1'b0, 40);
    check("dis_ping_before", ping_cnt, 1);
    check("dis_pulses",      dis_pulses, 0);
    check("dis_vld",         vld_cnt, 0);
    check("dis_done",        done_cnt, 0);
    check("dis_state",       {29'd0, dbg_state}, 0);
    check("dis_byte_hold",   {24'd0, bus.rx_byte}, 32'h88);
    bus.rx_en = 1'b1;
    set_line(1'b0, 20);

    // asynchronous reset in the middle of DATA
    clear_counts();
    send_ping();
    sync_to(1'b0);
    set_line(1'b0, 20);
    set_line(1'b0, 20);
    set_line(1'b1, 20);
    check("pre_rst_state", {29'd0, dbg_state}, 3);
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    set_line(1'b0, 3);
    rst = 1'b0;
    set_line(1'b0, 20);
    check_all_zero("post_rst");
    run_frame('{1, 32'h96, 4'h0, 20, 32'h96, 4'h0, 2'd1, 1'b1}, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
